// File: rtl/wash_sequencer_if.sv
// Bundle between the top-level sequencer and the wash-phase engine:
// stage control in, display/status/progress out.
interface wash_sequencer_if;
  logic        en;
  logic [1:0]  mode;
  logic        m_pos;
  logic [7:0]  led;
  logic [3:0]  ena;
  logic [7:0]  st_light;
  logic [7:0]  wt_light;
  logic [11:0] run_sec;
  logic        done;

  modport master (
    output en, mode, m_pos,
    input  led, ena, st_light, wt_light, run_sec, done
  );

  modport slave (
    input  en, mode, m_pos,
    output led, ena, st_light, wt_light, run_sec, done
  );
endinterface

// File: rtl/wash_sequencer.sv
// Wash-phase engine: runs fill/wash/drain/spin on a one-second tick, shows the
// remaining phase seconds on a scanned 4-digit display and reports run time.
module wash_sequencer #(
  parameter int TICK_DIV = 100000000,
  parameter int SCAN_DIV = 100000,
  parameter int WASH_S   = 20,
  parameter int SPIN_S   = 10
) (
  input  logic            clk,
  input  logic            rst,
  wash_sequencer_if.slave bus
);

  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV + 1);

  typedef enum logic [2:0] {IDLE, FILL, WASH, DRAIN, SPIN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         mode_reg, mode_next;
  logic [TICK_W-1:0]  tick_cnt_reg, tick_cnt_next;
  logic [3:0]         level_reg, level_next;
  logic [13:0]        phase_reg, phase_next;
  logic               paused_reg, paused_next;
  logic [11:0]        run_sec_reg, run_sec_next;
  logic [SCAN_W-1:0]  scan_cnt_reg, scan_cnt_next;
  logic [1:0]         digit_reg, digit_next;
  logic [3:0]         ena_reg, ena_next;
  logic [7:0]         led_reg, led_next;

  logic        active;
  logic        tick;
  logic [3:0]  target;
  logic [13:0] remain;
  logic [15:0] bcd;
  logic [3:0]  digit_val;
  logic [7:0]  therm;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  assign active = (state_reg == FILL) || (state_reg == WASH) ||
                  (state_reg == DRAIN) || (state_reg == SPIN);
  assign tick   = active && !paused_reg && (tick_cnt_reg == TICK_W'(TICK_DIV - 1));

  always_comb begin
    target = 4'd0;
    case (mode_reg)
      2'd1:    target = 4'd3;
      2'd2:    target = 4'd5;
      2'd3:    target = 4'd8;
      default: target = 4'd0;
    endcase
  end

  always_comb begin
    remain = 14'd0;
    case (state_reg)
      FILL:       remain = {10'b0, target - level_reg};
      WASH, SPIN: remain = phase_reg;
      DRAIN:      remain = {10'b0, level_reg};
      default:    remain = 14'd0;
    endcase
  end

  // Double-dabble: shift remain in MSB first, correcting digits >= 5 before each shift.
  always_comb begin
    bcd = 16'd0;
    for (int i = 13; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], remain[i]};
    end
  end

  // The water level is kept as a count; the lights are its thermometer image.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_therm
      assign therm[gi] = (level_reg > 4'(gi));
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    tick_cnt_next = tick_cnt_reg;
    level_next    = level_reg;
    phase_next    = phase_reg;
    paused_next   = paused_reg;
    run_sec_next  = run_sec_reg;
    scan_cnt_next = scan_cnt_reg;
    digit_next    = digit_reg;
    ena_next      = ena_reg;
    led_next      = led_reg;
    digit_val     = 4'd0;

    case (state_reg)
      IDLE: begin
        if (bus.en) begin
          mode_next  = bus.mode;
          level_next = 4'd0;
          if (bus.mode == 2'd0) begin
            state_next = SPIN;
            phase_next = 14'(SPIN_S);
          end else begin
            state_next = FILL;
            phase_next = 14'd0;
          end
        end
      end
      FILL: begin
        if (tick) begin
          level_next = level_reg + 4'd1;
          if (level_reg + 4'd1 >= target) begin
            state_next = WASH;
            phase_next = 14'(WASH_S);
          end
        end
      end
      WASH: begin
        if (tick) begin
          phase_next = phase_reg - 14'd1;
          if (phase_reg <= 14'd1) begin
            phase_next = 14'd0;
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (tick) begin
          level_next = level_reg - 4'd1;
          if (level_reg <= 4'd1) begin
            level_next = 4'd0;
            state_next = SPIN;
            phase_next = 14'(SPIN_S);
          end
        end
      end
      SPIN: begin
        if (tick) begin
          phase_next = phase_reg - 14'd1;
          if (phase_reg <= 14'd1) begin
            phase_next = 14'd0;
            state_next = DONE;
          end
        end
      end
      default: ;
    endcase

    // Counter restarts on every phase entry so each phase gets whole seconds.
    if (state_next != state_reg) tick_cnt_next = '0;
    else if (active && !paused_reg) tick_cnt_next = tick ? '0 : tick_cnt_reg + 1'b1;

    // Toggle is evaluated against the pre-pulse paused flag, so a coincident tick still lands.
    if (active && bus.m_pos) paused_next = !paused_reg;
    if (state_next == DONE) paused_next = 1'b0;

    if (state_reg == IDLE) run_sec_next = 12'd0;
    else if (tick && run_sec_reg != 12'hFFF) run_sec_next = run_sec_reg + 12'd1;

    if (state_reg == IDLE) begin
      scan_cnt_next = '0;
      digit_next    = 2'd0;
      ena_next      = 4'd0;
      led_next      = 8'd0;
    end else begin
      if (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt_next = '0;
        digit_next    = digit_reg + 2'd1;
      end else begin
        scan_cnt_next = scan_cnt_reg + 1'b1;
      end
      digit_val = bcd[4*digit_next +: 4];
      ena_next  = 4'b0001 << digit_next;
      led_next  = seg7(digit_val);
    end

    // Dropping the stage enable abandons the run, including the latched program.
    if (!bus.en) begin
      state_next    = IDLE;
      mode_next     = 2'd0;
      tick_cnt_next = '0;
      level_next    = 4'd0;
      phase_next    = 14'd0;
      paused_next   = 1'b0;
      run_sec_next  = 12'd0;
      scan_cnt_next = '0;
      digit_next    = 2'd0;
      ena_next      = 4'd0;
      led_next      = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      mode_reg     <= 2'd0;
      tick_cnt_reg <= '0;
      level_reg    <= 4'd0;
      phase_reg    <= 14'd0;
      paused_reg   <= 1'b0;
      run_sec_reg  <= 12'd0;
      scan_cnt_reg <= '0;
      digit_reg    <= 2'd0;
      ena_reg      <= 4'd0;
      led_reg      <= 8'd0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      tick_cnt_reg <= tick_cnt_next;
      level_reg    <= level_next;
      phase_reg    <= phase_next;
      paused_reg   <= paused_next;
      run_sec_reg  <= run_sec_next;
      scan_cnt_reg <= scan_cnt_next;
      digit_reg    <= digit_next;
      ena_reg      <= ena_next;
      led_reg      <= led_next;
    end
  end

  assign bus.led      = led_reg;
  assign bus.ena      = ena_reg;
  assign bus.wt_light = active ? therm : 8'h00;
  assign bus.st_light = {state_reg == DONE, paused_reg, 2'b00,
                         state_reg == SPIN, state_reg == DRAIN,
                         state_reg == WASH, state_reg == FILL};
  assign bus.run_sec  = run_sec_reg;
  assign bus.done     = (state_reg == DONE);

endmodule

// File: doc/wash_sequencer.md
Name: wash_sequencer

Overview:
- Wash-phase engine between the preparation stage (mode selection, balance) and the billing stage.
- While enabled, it runs the selected program through timed phases: fill, wash, drain, spin.
- Drives one 4-digit seven-segment group with the remaining phase seconds, plus the status and water-level lights.
- Reports elapsed run seconds and a done flag to the top-level sequencer, which then hands over to billing.

Parameters:
- TICK_DIV, 100000000, clk cycles per one-second tick
- SCAN_DIV, 100000, clk cycles per digit-scan step
- WASH_S, 20, wash phase length in seconds
- SPIN_S, 10, spin phase length in seconds (also the whole dry program)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- en  in  1  stage enable from top; low forces IDLE
- mode  in  2  program: 0 dry, 1 small, 2 medium, 3 big; sampled on IDLE->start
- m_pos  in  1  debounced single-cycle middle-button pulse; toggles pause
- led  out  8  segment pattern, bit0..6 = a..g, bit7 = dp, active-high
- ena  out  4  digit enable, one-hot active-high, bit0 = rightmost digit
- st_light  out  8  status lights
- wt_light  out  8  water-level thermometer
- run_sec  out  12  elapsed unpaused seconds, saturating at 4095
- done  out  1  program finished

Behaviour:
- Reset (rst low, asynchronous) or en low: state IDLE, and every output = 0.
  - Tick, scan and phase counters are cleared; the paused flag is cleared.
- States: IDLE, FILL, WASH, DRAIN, SPIN, DONE.
- IDLE:
  - When en=1, latch mode.
  - Next cycle go to FILL, or to SPIN when mode=0.
- Water level target L: mode1 = 3, mode2 = 5, mode3 = 8.
- Tick counter:
  - Counts 0..TICK_DIV-1 only when not paused and state is FILL..SPIN.
  - Wraps to 0; the wrap cycle is the "tick".
  - Counter is cleared on every phase entry.
- FILL:
  - Each tick shifts one more 1 into wt_light from bit0.
  - When the popcount reaches L, go to WASH on that same tick.
  - Remaining time = L minus current level.
- WASH:
  - Remaining time loads WASH_S on entry and decrements each tick.
  - On the tick taking it 1->0, go to DRAIN.
- DRAIN:
  - Each tick clears the highest set bit of wt_light.
  - When wt_light becomes 0, go to SPIN.
  - Remaining time = current level.
- SPIN:
  - Loads SPIN_S and counts down like WASH.
  - At 0, go to DONE.
- DONE:
  - done=1, st_light[7]=1, wt_light=0, display shows 0000.
  - Holds until en falls.
- run_sec:
  - Cleared in IDLE.
  - +1 on every tick in FILL..SPIN; saturates at 4095.
- st_light:
  - Bits 0..3 one-hot for FILL, WASH, DRAIN, SPIN.
  - Bit 6 = paused; bit 7 = DONE; bits 4..5 = 0.
- Pause:
  - m_pos in FILL..SPIN toggles paused.
  - While paused, the tick counter and all phase state freeze; the display keeps scanning.
  - m_pos in IDLE or DONE is ignored.
  - If m_pos and a tick occur in the same cycle, the tick is applied first, then the pause takes effect.
- Display:
  - Remaining seconds (0..9999) converted to 4 BCD digits.
  - The scan counter advances the ena one-hot every SCAN_DIV cycles: bit0 -> bit1 -> bit2 -> bit3 -> bit0.
  - led holds the digit selected by the current ena bit, with the same-cycle registered update.
  - Leading zeros are shown; dp is always 0.
  - Seven-segment codes for 0-9 are standard a..g.
- en falling mid-run: next edge returns to IDLE with all outputs 0; the latched mode is discarded.

Test Plan:
- Reset check, using parameters TICK_DIV=4, SCAN_DIV=2, WASH_S=3, SPIN_S=2 for all scenarios: hold rst low for 3 cycles with en=1 -> all outputs 0; after release, FILL begins the next cycle.
- mode=1, en=1 -> FILL lasts 3 ticks with wt_light 0x01, 0x03, 0x07; WASH 3 ticks; DRAIN 3 ticks back to 0x00; SPIN 2 ticks; then done=1, st_light=0x80, run_sec=11.
- mode=0 -> goes straight to SPIN with st_light=0x08; done after 2 ticks (8 cycles); run_sec=2; wt_light stays 0.
- mode=3 -> wt_light reaches 0xFF; during WASH the scan shows digits 0,0,0,3 with ena cycling 0001, 0010, 0100, 1000; led=0x4F when digit 3 is enabled.
- Pulse m_pos in WASH with 2 s remaining -> st_light=0x42 and remaining time and run_sec frozen for 20 cycles; a second m_pos resumes, and the phase finishes exactly 2 ticks later.
- Drop en in DRAIN -> next cycle all outputs 0; raising en again restarts at FILL with run_sec=0 and re-latched mode.
